// File: rtl/acs_ctrl.sv
// acs_ctrl: frame sequencer for the 64-state Viterbi ACS array.
// Gates branch metrics, clears path metrics, writes survivors, hands off to traceback.
module acs_ctrl #(
  parameter int BM_WIDTH      = 9,
  parameter int SM_ADDR_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic [SM_ADDR_WIDTH:0]   cfg_frame_len,
  input  logic [BM_WIDTH-1:0]      in_bm0,
  input  logic [BM_WIDTH-1:0]      in_bm1,
  input  logic [BM_WIDTH-1:0]      in_bm2,
  input  logic [BM_WIDTH-1:0]      in_bm3,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [BM_WIDTH-1:0]      acs_bm0,
  output logic [BM_WIDTH-1:0]      acs_bm1,
  output logic [BM_WIDTH-1:0]      acs_bm2,
  output logic [BM_WIDTH-1:0]      acs_bm3,
  output logic                     acs_bm_valid,
  output logic                     acs_pm_clear,
  input  logic [63:0]              acs_ph,
  output logic                     sm_we,
  output logic [SM_ADDR_WIDTH-1:0] sm_waddr,
  output logic [63:0]              sm_wdata,
  output logic                     tb_start,
  output logic [SM_ADDR_WIDTH-1:0] tb_last_addr,
  input  logic                     tb_done,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     cfg_err
);

  localparam int AW = SM_ADDR_WIDTH;
  localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    TB_REQ,
    TB_WAIT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [AW:0]   len_q;
  logic [AW:0]   step_q;
  logic [AW:0]   wr_q;
  logic [2:0]    vld_pipe;
  logic [AW-1:0] len_lo;
  logic          len_ok;
  logic          accept;
  logic          beat;
  logic          last_beat;
  logic          last_wr;

  assign len_ok    = (cfg_frame_len != '0)
                  && (cfg_frame_len <= MAX_LEN);
  assign accept    = (state == IDLE)
                  && frame_start && len_ok;
  assign beat      = in_valid && in_ready;
  assign last_beat = beat && ((step_q + ONE) == len_q);
  // The final write is in flight this cycle, so the
  // traceback request can go out on the very next one.
  assign last_wr   = (wr_q == len_q)
                  || (sm_we && ((wr_q + ONE) == len_q));
  assign len_lo    = len_q[AW-1:0];

  assign sm_we    = vld_pipe[2];
  assign sm_waddr = wr_q[AW-1:0];
  assign sm_wdata = acs_ph;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    acs_pm_clear = 1'b0;
    tb_start     = 1'b0;
    busy         = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = CLEAR;
      end
      CLEAR: begin
        acs_pm_clear = 1'b1;
        state_nxt    = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_wr) state_nxt = TB_REQ;
      end
      TB_REQ: begin
        tb_start  = 1'b1;
        state_nxt = TB_WAIT;
      end
      TB_WAIT: begin
        if (tb_done) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Frame length and step counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q  <= '0;
      step_q <= '0;
    end else if (accept) begin
      len_q  <= cfg_frame_len;
      step_q <= '0;
    end else if (beat) begin
      step_q <= step_q + ONE;
    end
  end

  // Branch-metric register toward the ACS array.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acs_bm0 <= '0;
      acs_bm1 <= '0;
      acs_bm2 <= '0;
      acs_bm3 <= '0;
    end else if (beat) begin
      acs_bm0 <= in_bm0;
      acs_bm1 <= in_bm1;
      acs_bm2 <= in_bm2;
      acs_bm3 <= in_bm3;
    end
  end

  // Step strobe and its delay line matching ACS latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acs_bm_valid <= 1'b0;
      vld_pipe     <= '0;
    end else begin
      acs_bm_valid <= beat;
      vld_pipe     <= {vld_pipe[1:0], acs_bm_valid};
    end
  end

  // Survivor write address counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
    end else if (accept) begin
      wr_q <= '0;
    end else if (sm_we) begin
      wr_q <= wr_q + ONE;
    end
  end

  // Traceback last address, held until the next request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tb_last_addr <= '0;
    end else if ((state == DRAIN) && last_wr) begin
      tb_last_addr <= len_lo - ONE_A;
    end
  end

  // One-cycle status pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      frame_done <= (state == TB_WAIT) && tb_done;
      cfg_err    <= (state == IDLE) && frame_start
                 && !len_ok;
    end
  end

endmodule

// File: tb/tb_acs_ctrl.sv
// tb_acs_ctrl: scoreboard bench for acs_ctrl.
// Driver queues expected output events; negedge monitor pops and compares.
module tb_acs_ctrl;

  localparam int BW = 9;
  localparam int AW = 8;
  localparam int QBM  = 0;
  localparam int QWR  = 1;
  localparam int QCLR = 2;
  localparam int QTB  = 3;
  localparam int QFD  = 4;
  localparam int QERR = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          frame_start = 1'b0;
  logic [AW:0]   cfg_frame_len = '0;
  logic [BW-1:0] in_bm0 = '0;
  logic [BW-1:0] in_bm1 = '0;
  logic [BW-1:0] in_bm2 = '0;
  logic [BW-1:0] in_bm3 = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] acs_bm0, acs_bm1, acs_bm2, acs_bm3;
  logic          acs_bm_valid;
  logic          acs_pm_clear;
  logic [63:0]   acs_ph = '0;
  logic          sm_we;
  logic [AW-1:0] sm_waddr;
  logic [63:0]   sm_wdata;
  logic          tb_start;
  logic [AW-1:0] tb_last_addr;
  logic          tb_done = 1'b0;
  logic          busy;
  logic          frame_done;
  logic          cfg_err;

  int cyc = 0;
  int nerr = 0;
  int nchk = 0;

  typedef struct {
    int          c;
    logic [63:0] d;
  } ev_t;

  ev_t   q[6][$];
  string qn[6] = '{"acs_bm_valid", "sm_we", "acs_pm_clear",
                   "tb_start", "frame_done", "cfg_err"};

  acs_ctrl #(.BM_WIDTH(BW), .SM_ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .frame_start(frame_start), .cfg_frame_len(cfg_frame_len),
    .in_bm0(in_bm0), .in_bm1(in_bm1),
    .in_bm2(in_bm2), .in_bm3(in_bm3),
    .in_valid(in_valid), .in_ready(in_ready),
    .acs_bm0(acs_bm0), .acs_bm1(acs_bm1),
    .acs_bm2(acs_bm2), .acs_bm3(acs_bm3),
    .acs_bm_valid(acs_bm_valid), .acs_pm_clear(acs_pm_clear),
    .acs_ph(acs_ph),
    .sm_we(sm_we), .sm_waddr(sm_waddr), .sm_wdata(sm_wdata),
    .tb_start(tb_start), .tb_last_addr(tb_last_addr),
    .tb_done(tb_done), .busy(busy),
    .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clock);
      #3;
      acs_ph = {$urandom(), $urandom()};
    end
  end

  task automatic push(int k, int c, logic [63:0] d);
    ev_t e;
    e.c = c;
    e.d = d;
    q[k].push_back(e);
  endtask

  task automatic flush(int c);
    for (int k = 0; k < 6; k++)
      while (q[k].size() > 0 && q[k][q[k].size()-1].c >= c)
        void'(q[k].pop_back());
  endtask

  task automatic chk(int k, logic hit, logic [63:0] d);
    while (q[k].size() > 0 && q[k][0].c < cyc) begin
      nchk++;
      nerr++;
      $display("FAIL %s missed: expected in cycle %0d, not seen",
               qn[k], q[k][0].c);
      void'(q[k].pop_front());
    end
    if (hit) begin
      nchk++;
      if (q[k].size() == 0 || q[k][0].c != cyc) begin
        nerr++;
        $display("FAIL %s unexpected in cycle %0d (data %0h)",
                 qn[k], cyc, d);
      end else begin
        if (q[k][0].d !== d) begin
          nerr++;
          $display("FAIL %s data in cycle %0d: got %0h expected %0h",
                   qn[k], cyc, d, q[k][0].d);
        end
        void'(q[k].pop_front());
      end
    end
  endtask

  always @(negedge clock) begin
    chk(QBM, acs_bm_valid,
        {28'd0, acs_bm3, acs_bm2, acs_bm1, acs_bm0});
    chk(QWR, sm_we, {56'd0, sm_waddr});
    if (sm_we) begin
      nchk++;
      if (sm_wdata !== acs_ph) begin
        nerr++;
        $display("FAIL sm_wdata in cycle %0d: got %0h expected %0h",
                 cyc, sm_wdata, acs_ph);
      end
    end
    chk(QCLR, acs_pm_clear, 64'd0);
    chk(QTB, tb_start, {56'd0, tb_last_addr});
    chk(QFD, frame_done, 64'd0);
    chk(QERR, cfg_err, 64'd0);
  end

  task automatic ce(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s in cycle %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_quiet(string tag);
    ce({tag, " in_ready"}, in_ready, 0);
    ce({tag, " acs_bm_valid"}, acs_bm_valid, 0);
    ce({tag, " acs_bm"},
       {acs_bm3, acs_bm2, acs_bm1, acs_bm0}, 0);
    ce({tag, " acs_pm_clear"}, acs_pm_clear, 0);
    ce({tag, " sm_we"}, sm_we, 0);
    ce({tag, " sm_waddr"}, sm_waddr, 0);
    ce({tag, " sm_wdata"}, sm_wdata, acs_ph);
    ce({tag, " tb_start"}, tb_start, 0);
    ce({tag, " tb_last_addr"}, tb_last_addr, 0);
    ce({tag, " busy"}, busy, 0);
    ce({tag, " frame_done"}, frame_done, 0);
    ce({tag, " cfg_err"}, cfg_err, 0);
  endtask

  task automatic start_bad(int len);
    ce("bad idle busy", busy, 0);
    frame_start   = 1'b1;
    cfg_frame_len = (AW+1)'(len);
    push(QERR, cyc + 1, 0);
    step();
    frame_start = 1'b0;
    ce("bad stays idle", busy, 0);
    ce("bad in_ready", in_ready, 0);
    step();
  endtask

  // poke: bit0 frame_start in RUN, bit1 tb_done in RUN,
  // bit2 frame_start (len 0) in TB_WAIT
  task automatic do_frame(int len, int mode, int poke, int kill);
    int   s;
    int   got;
    int   tl;
    logic v;
    ce("idle busy", busy, 0);
    s             = cyc;
    frame_start   = 1'b1;
    cfg_frame_len = (AW+1)'(len);
    push(QCLR, s + 1, 0);
    step();
    frame_start = 1'b0;
    ce("clear in_ready", in_ready, 0);
    ce("clear busy", busy, 1);
    step();
    got = 0;
    tl  = cyc;
    while (got < len) begin
      if (cyc - s > 4 * len + 50) begin
        nchk++;
        nerr++;
        $display("FAIL frame timeout: %0d of %0d beats", got, len);
        break;
      end
      ce("run in_ready", in_ready, 1);
      case (mode)
        0:       v = 1'b1;
        1:       v = ((cyc - s) % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_bm0   = (mode == 0) ? BW'(got + 1) : BW'($urandom());
      in_bm1   = BW'($urandom());
      in_bm2   = BW'($urandom());
      in_bm3   = BW'($urandom());
      if (poke[0] && got == 2) begin
        frame_start   = 1'b1;
        cfg_frame_len = (AW+1)'(3);
      end
      if (poke[1] && got == 1) tb_done = 1'b1;
      if (v) begin
        push(QBM, cyc + 1, {28'd0, in_bm3, in_bm2, in_bm1, in_bm0});
        push(QWR, cyc + 4, 64'(got));
        got++;
        tl = cyc;
      end
      step();
      in_valid    = 1'b0;
      frame_start = 1'b0;
      tb_done     = 1'b0;
      if (kill > 0 && got == kill) begin
        flush(cyc);
        reset = 1'b0;
        #1;
        check_quiet("kill");
        repeat (3) step();
        reset = 1'b1;
        step();
        return;
      end
    end
    ce("in_ready after last", in_ready, 0);
    push(QTB, tl + 5, 64'(len - 1));
    while (cyc < tl + 8) begin
      if (poke[2] && cyc == tl + 6) begin
        frame_start   = 1'b1;
        cfg_frame_len = '0;
      end
      step();
      frame_start = 1'b0;
    end
    ce("tb_wait busy", busy, 1);
    ce("tb_last_addr held", tb_last_addr, 64'(len - 1));
    tb_done = 1'b1;
    push(QFD, cyc + 1, 0);
    step();
    tb_done = 1'b0;
    ce("done busy", busy, 0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) step();
    check_quiet("reset");
    reset = 1'b1;
    step();
    do_frame(4, 0, 0, 0);
    do_frame(6, 1, 0, 0);
    start_bad(0);
    start_bad(257);
    do_frame(5, 0, 5, 0);
    do_frame(5, 2, 2, 0);
    do_frame(256, 0, 0, 0);
    do_frame(8, 0, 0, 3);
    do_frame(2, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      do_frame(int'($urandom_range(1, 24)), 2, 0, 0);
    do_frame(1, 0, 0, 0);
    do_frame(1, 2, 0, 0);
    repeat (10) step();
    for (int k = 0; k < 6; k++) begin
      while (q[k].size() > 0) begin
        nchk++;
        nerr++;
        $display("FAIL %s never seen: expected in cycle %0d",
                 qn[k], q[k][0].c);
        void'(q[k].pop_front());
      end
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
